// File: rtl/jtag_bridge_pkg.sv
// Shared constants and width helpers for the JTAG stream bridge and its FIFOs.
package jtag_bridge_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 64;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Occupancy counters need one extra bit so that "full" is representable.
    function automatic int level_w(input int depth);
        return clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/jtag_sync_fifo.sv
// Synchronous FIFO, non-showahead: q is registered and updates one cycle after a read.
// Writes while full and reads while empty are ignored; clear flushes pointers and count.
module jtag_sync_fifo import jtag_bridge_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      wr_en,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic                      rd_en,
    output logic [DATA_W-1:0]         q,
    output logic [level_w(DEPTH)-1:0] count,
    output logic                      full,
    output logic                      empty
);
    localparam int AW = clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr, rptr;
    logic              do_wr, do_rd;

    assign full  = (count == LW'(DEPTH));
    assign empty = (count == '0);
    assign do_wr = wr_en & ~full & ~clear;
    assign do_rd = rd_en & ~empty & ~clear;

    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            q     <= '0;
        end else if (clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_wr) wptr <= wptr + 1'b1;
            if (do_rd) begin
                rptr <= rptr + 1'b1;
                q    <= mem[rptr];
            end
            count <= count + LW'(do_wr) - LW'(do_rd);
        end
    end

endmodule

// File: rtl/jtag_stream_bridge.sv
// Stream bridge between user valid/ready streams and an Atlantic-style JTAG transport port.
// Optional internal TX->RX loopback is built when JTAG_STREAM_LOOPBACK_EN is defined.
module jtag_stream_bridge import jtag_bridge_pkg::*; #(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int TX_FIFO_EN = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
`ifdef JTAG_STREAM_LOOPBACK_EN
    input  logic                      loopback,
`endif
    input  logic                      clear,
    input  logic                      tx_valid,
    input  logic [DATA_W-1:0]         tx_data,
    output logic                      tx_ready,
    output logic                      rx_valid,
    output logic [DATA_W-1:0]         rx_data,
    input  logic                      rx_ready,
    output logic [level_w(DEPTH)-1:0] tx_level,
    output logic [level_w(DEPTH)-1:0] rx_level,
    output logic                      rx_overflow,
    output logic [DATA_W-1:0]         jtag_r_dat,
    input  logic                      jtag_r_ena,
    output logic                      jtag_r_val,
    input  logic [DATA_W-1:0]         jtag_t_dat,
    input  logic                      jtag_t_ena,
    output logic                      jtag_t_dav
);
    localparam int LW = level_w(DEPTH);

    logic              tx_push, tx_pop, tx_full, tx_empty, tx_out_vld;
    logic [DATA_W-1:0] tx_q;

    logic              rx_in_vld, rx_accept, rx_full, rx_take, out_free, q_to_out, bypass;
    logic              rf_push, rf_pop, rf_full, rf_empty, rq_vld, out_vld, t_dav_q;
    logic [DATA_W-1:0] rx_in_dat, rf_q, out_dat;
    logic [LW-1:0]     rf_cnt, rx_cnt, rx_cnt_next;

    // ---------------- TX: user -> JTAG ----------------
    assign tx_ready = ~tx_full;
    assign tx_push  = tx_valid & ~tx_full;
`ifdef JTAG_STREAM_LOOPBACK_EN
    assign tx_pop   = ~clear & ~tx_empty & (loopback ? ~rx_full : jtag_r_ena);
`else
    assign tx_pop   = ~clear & ~tx_empty & jtag_r_ena;
`endif

    generate
        if (TX_FIFO_EN != 0) begin : g_tx_fifo
            jtag_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
                .clk     (clk),
                .rst_n   (rst_n),
                .clear   (clear),
                .wr_en   (tx_push),
                .wr_data (tx_data),
                .rd_en   (tx_pop),
                .q       (tx_q),
                .count   (tx_level),
                .full    (tx_full),
                .empty   (tx_empty)
            );
        end else begin : g_tx_reg
            // Single holding slot; q mirrors the FIFO's registered read port.
            logic              held;
            logic [DATA_W-1:0] hold_dat, q_r;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    held     <= 1'b0;
                    hold_dat <= '0;
                    q_r      <= '0;
                end else if (clear) begin
                    held     <= 1'b0;
                end else if (tx_push) begin
                    held     <= 1'b1;
                    hold_dat <= tx_data;
                end else if (tx_pop) begin
                    held     <= 1'b0;
                    q_r      <= hold_dat;
                end
            end

            assign tx_full  = held;
            assign tx_empty = ~held;
            assign tx_q     = q_r;
            assign tx_level = LW'(held);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx_out_vld <= 1'b0;
        else        tx_out_vld <= tx_pop;
    end

    assign jtag_r_dat = tx_q;

    // ---------------- RX: JTAG -> user ----------------
`ifdef JTAG_STREAM_LOOPBACK_EN
    assign rx_in_vld  = loopback ? tx_out_vld : jtag_t_ena;
    assign rx_in_dat  = loopback ? tx_q       : jtag_t_dat;
    assign jtag_r_val = tx_out_vld & ~loopback;
    assign jtag_t_dav = t_dav_q & ~loopback;
`else
    assign rx_in_vld  = jtag_t_ena;
    assign rx_in_dat  = jtag_t_dat;
    assign jtag_r_val = tx_out_vld;
    assign jtag_t_dav = t_dav_q;
`endif

    // Occupancy spans storage, the FIFO read register and the output register.
    assign rx_cnt      = rf_cnt + LW'(rq_vld) + LW'(out_vld);
    assign rx_full     = (rx_cnt == LW'(DEPTH));
    assign rx_accept   = rx_in_vld & ~rx_full & ~clear;
    assign rx_take     = out_vld & rx_ready;
    assign out_free    = ~out_vld | rx_take;
    assign q_to_out    = out_free & rq_vld;
    // An empty pipeline lets a new word go straight to the output register.
    assign bypass      = rx_accept & out_free & ~rq_vld & rf_empty;
    assign rf_push     = rx_accept & ~bypass & ~rf_full;
    assign rf_pop      = ~rf_empty & (~rq_vld | q_to_out);
    assign rx_cnt_next = rx_cnt + LW'(rx_accept) - LW'(rx_take);

    jtag_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .wr_en   (rf_push),
        .wr_data (rx_in_dat),
        .rd_en   (rf_pop),
        .q       (rf_q),
        .count   (rf_cnt),
        .full    (rf_full),
        .empty   (rf_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rq_vld      <= 1'b0;
            out_vld     <= 1'b0;
            out_dat     <= '0;
            rx_overflow <= 1'b0;
            t_dav_q     <= 1'b1;
        end else if (clear) begin
            rq_vld      <= 1'b0;
            out_vld     <= 1'b0;
            rx_overflow <= 1'b0;
            t_dav_q     <= 1'b1;
        end else begin
            if (rf_pop)        rq_vld <= 1'b1;
            else if (q_to_out) rq_vld <= 1'b0;

            if (q_to_out) begin
                out_vld <= 1'b1;
                out_dat <= rf_q;
            end else if (bypass) begin
                out_vld <= 1'b1;
                out_dat <= rx_in_dat;
            end else if (rx_take) begin
                out_vld <= 1'b0;
            end

            if (rx_in_vld & rx_full) rx_overflow <= 1'b1;
            // Leaves one slot of slack for a transport reacting a cycle late.
            t_dav_q <= (rx_cnt_next <= LW'(DEPTH - 2));
        end
    end

    assign rx_valid = out_vld;
    assign rx_data  = out_dat;
    assign rx_level = rx_cnt;

endmodule
